// File: rtl/motor_pwm_ctrl.sv
// motor_pwm_ctrl: soft-start/soft-stop sequencer for the motor PWM driver.
// Ramps the driver high count toward a clamped target one step per ramp tick.
// Counts change only right after a rising edge of the fed-back pwm output.
// An external fault or a missing-feedback watchdog shuts the driver off at once.
module motor_pwm_ctrl #(
  parameter int unsigned PERIOD       = 1000,
  parameter int unsigned MIN_HIGH     = 4,
  parameter int unsigned STEP         = 1,
  parameter int unsigned RAMP_PERIODS = 50,
  parameter int unsigned WDOG_CYCLES  = 2*PERIOD+8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] target_high,
  input  logic        fault,
  input  logic        fault_clr,
  input  logic        pwm_fb,
  output logic        pwm_en,
  output logic [15:0] high_cnt,
  output logic [15:0] low_cnt,
  output logic        at_speed,
  output logic        busy,
  output logic [1:0]  fault_code
);

  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
  localparam int unsigned TK_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

  localparam logic [15:0]     P16     = 16'(PERIOD);
  localparam logic [15:0]     MIN16   = 16'(MIN_HIGH);
  localparam logic [15:0]     MAX16   = 16'(PERIOD - MIN_HIGH);
  localparam logic [15:0]     STEP16  = 16'(STEP);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(RAMP_PERIODS - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_EXT  = 2'd1;
  localparam logic [1:0] FC_WDOG = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_RUN   = 4'b0010,
    S_STOP  = 4'b0100,
    S_FAULT = 4'b1000
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_fb_q;
  logic [TK_W-1:0] r_tick_cnt;
  logic [WD_W-1:0] r_wd_cnt;
  logic [15:0]     r_high;
  logic            r_at_speed;
  logic [1:0]      r_fcode;

  logic            w_active;
  logic            w_nxt_active;
  logic            w_run_entry;
  logic            w_bnd;
  logic            w_tick;
  logic            w_wd_exp;
  logic [15:0]     w_tgt;
  logic [15:0]     w_high_nxt;
  logic [1:0]      w_fcode_nxt;

  // Limit the commanded count so neither PWM phase drops below MIN_HIGH.
  function automatic logic [15:0] f_clamp(input logic [15:0] v);
    if (v < MIN16)      return MIN16;
    else if (v > MAX16) return MAX16;
    else                return v;
  endfunction

  // Move cur toward goal by at most STEP, landing exactly on goal.
  function automatic logic [15:0] f_ramp(input logic [15:0] cur, input logic [15:0] goal);
    logic [15:0] diff;
    if (cur < goal) begin
      diff = goal - cur;
      return (diff < STEP16) ? goal : cur + STEP16;
    end else begin
      diff = cur - goal;
      return (diff < STEP16) ? goal : cur - STEP16;
    end
  endfunction

  assign w_tgt        = f_clamp(target_high);
  assign w_active     = (r_state == S_RUN) || (r_state == S_STOP);
  assign w_nxt_active = (w_state_nxt == S_RUN) || (w_state_nxt == S_STOP);
  assign w_run_entry  = (r_state == S_IDLE) && (w_state_nxt == S_RUN);
  assign w_bnd        = pwm_fb & ~r_fb_q;
  assign w_tick       = w_active && w_bnd && (r_tick_cnt == TK_LAST);
  // A boundary this cycle restarts the watchdog, so it cannot expire with it.
  assign w_wd_exp     = w_active && !w_bnd && (r_wd_cnt >= WD_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and fault code; external fault outranks watchdog, then stop, then start.
  always_comb begin
    w_state_nxt = r_state;
    w_fcode_nxt = r_fcode;
    case (r_state)
      S_IDLE: begin
        if (fault) begin
          w_state_nxt = S_FAULT;
          w_fcode_nxt = FC_EXT;
        end else if (start && !stop) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (fault) begin
          w_state_nxt = S_FAULT;
          w_fcode_nxt = FC_EXT;
        end else if (w_wd_exp) begin
          w_state_nxt = S_FAULT;
          w_fcode_nxt = FC_WDOG;
        end else if (stop) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (fault) begin
          w_state_nxt = S_FAULT;
          w_fcode_nxt = FC_EXT;
        end else if (w_wd_exp) begin
          w_state_nxt = S_FAULT;
          w_fcode_nxt = FC_WDOG;
        end else if (start && !stop) begin
          w_state_nxt = S_RUN;
        end else if (w_bnd && (r_high == MIN16)) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FAULT: begin
        if (fault_clr && !fault) begin
          w_state_nxt = S_IDLE;
          w_fcode_nxt = FC_NONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_fcode_nxt = FC_NONE;
      end
    endcase
  end

  // Next high count: forced to the minimum when stopped, else stepped on ramp ticks.
  always_comb begin
    w_high_nxt = r_high;
    if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_FAULT))
      w_high_nxt = MIN16;
    else if (w_tick)
      w_high_nxt = f_ramp(r_high, (r_state == S_RUN) ? w_tgt : MIN16);
  end

  // Feedback edge detector, ramp-tick and watchdog counters, counts and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fb_q     <= 1'b0;
      r_tick_cnt <= '0;
      r_wd_cnt   <= '0;
      r_high     <= MIN16;
      r_at_speed <= 1'b0;
      r_fcode    <= FC_NONE;
    end else begin
      r_fb_q  <= pwm_fb;
      r_high  <= w_high_nxt;
      r_fcode <= w_fcode_nxt;
      r_at_speed <= (w_state_nxt == S_RUN) && (w_high_nxt == w_tgt);
      if (!w_nxt_active || w_run_entry)
        r_tick_cnt <= '0;
      else if (w_bnd)
        r_tick_cnt <= (r_tick_cnt == TK_LAST) ? '0 : r_tick_cnt + TK_W'(1);
      if (!w_nxt_active || w_run_entry || w_bnd)
        r_wd_cnt <= '0;
      else
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  assign pwm_en     = w_active;
  assign busy       = w_active;
  assign high_cnt   = r_high;
  assign low_cnt    = P16 - r_high;
  assign at_speed   = r_at_speed;
  assign fault_code = r_fcode;

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// tb_motor_pwm_ctrl: directed bench for the soft-start/stop sequencer.
// PERIOD=100, MIN_HIGH=4, STEP=2, RAMP_PERIODS=1, WDOG_CYCLES=208.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_motor_pwm_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] target_high;
  logic        fault;
  logic        fault_clr;
  logic        pwm_fb;
  logic        pwm_en;
  logic [15:0] high_cnt;
  logic [15:0] low_cnt;
  logic        at_speed;
  logic        busy;
  logic [1:0]  fault_code;

  int n_checks;
  int n_fail;
  int exp_high;

  motor_pwm_ctrl #(
    .PERIOD(100),
    .MIN_HIGH(4),
    .STEP(2),
    .RAMP_PERIODS(1),
    .WDOG_CYCLES(208)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .target_high(target_high),
    .fault(fault),
    .fault_clr(fault_clr),
    .pwm_fb(pwm_fb),
    .pwm_en(pwm_en),
    .high_cnt(high_cnt),
    .low_cnt(low_cnt),
    .at_speed(at_speed),
    .busy(busy),
    .fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // n feedback periods of 4 cycles; high count expected to move 2 toward goal per rise.
  task automatic ramp(input int n, input int goal, input bit in_run);
    for (int i = 0; i < n; i++) begin
      pwm_fb = 1'b1;
      cyc(1);
      if (exp_high < goal)      exp_high = (goal - exp_high < 2) ? goal : exp_high + 2;
      else if (exp_high > goal) exp_high = (exp_high - goal < 2) ? goal : exp_high - 2;
      check("ramp_high", 32'(high_cnt), 32'(exp_high));
      check("ramp_low", 32'(low_cnt), 32'(100 - exp_high));
      check("ramp_en", 32'(pwm_en), 32'd1);
      check("ramp_at_speed", 32'(at_speed), 32'(in_run && (exp_high == goal)));
      cyc(1);
      pwm_fb = 1'b0;
      cyc(2);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; target_high = 16'd40;
    fault = 1'b0; fault_clr = 1'b0; pwm_fb = 1'b0;
    cyc(2);
    check("rst_en", 32'(pwm_en), 32'd0);
    check("rst_high", 32'(high_cnt), 32'd4);
    check("rst_low", 32'(low_cnt), 32'd96);
    check("rst_at_speed", 32'(at_speed), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fcode", 32'(fault_code), 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // Ramp up to 40
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("start_en", 32'(pwm_en), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_high", 32'(high_cnt), 32'd4);
    exp_high = 4;
    ramp(18, 40, 1'b1);
    check("up_at_speed", 32'(at_speed), 32'd1);
    ramp(2, 40, 1'b1);

    // Clamp low and high, then back to 40
    target_high = 16'd0;
    ramp(20, 4, 1'b1);
    target_high = 16'd200;
    ramp(48, 96, 1'b1);
    check("clamp_low_cnt", 32'(low_cnt), 32'd4);
    target_high = 16'd40;
    ramp(30, 40, 1'b1);

    // Soft stop
    stop = 1'b1;
    cyc(1);
    check("stop_busy", 32'(busy), 32'd1);
    check("stop_at_speed", 32'(at_speed), 32'd0);
    ramp(18, 4, 1'b0);
    pwm_fb = 1'b1;
    cyc(1);
    check("stop_done_en", 32'(pwm_en), 32'd0);
    check("stop_done_busy", 32'(busy), 32'd0);
    check("stop_done_high", 32'(high_cnt), 32'd4);
    pwm_fb = 1'b0;
    stop = 1'b0;
    cyc(2);

    // Restart during STOP at 20
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    exp_high = 4;
    ramp(18, 40, 1'b1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    ramp(10, 4, 1'b0);
    check("restart_mid", 32'(high_cnt), 32'd20);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("restart_en", 32'(pwm_en), 32'd1);
    check("restart_at_speed", 32'(at_speed), 32'd0);
    ramp(10, 40, 1'b1);

    // External fault during high phase
    pwm_fb = 1'b1;
    cyc(1);
    fault = 1'b1;
    cyc(1);
    check("xf_en", 32'(pwm_en), 32'd0);
    check("xf_code", 32'(fault_code), 32'd1);
    check("xf_high", 32'(high_cnt), 32'd4);
    check("xf_low", 32'(low_cnt), 32'd96);
    check("xf_at_speed", 32'(at_speed), 32'd0);
    pwm_fb = 1'b0;
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    check("xf_clr_held_code", 32'(fault_code), 32'd1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("xf_start_ignored", 32'(pwm_en), 32'd0);
    fault = 1'b0;
    cyc(1);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    check("xf_clr_code", 32'(fault_code), 32'd0);

    // Watchdog with feedback tied low
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("wd_run_en", 32'(pwm_en), 32'd1);
    cyc(207);
    check("wd_pre_en", 32'(pwm_en), 32'd1);
    check("wd_pre_code", 32'(fault_code), 32'd0);
    cyc(1);
    check("wd_exp_en", 32'(pwm_en), 32'd0);
    check("wd_exp_code", 32'(fault_code), 32'd2);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    check("wd_clr_code", 32'(fault_code), 32'd0);

    // Watchdog expiry coinciding with external fault
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(207);
    fault = 1'b1;
    cyc(1);
    check("wdx_code", 32'(fault_code), 32'd1);
    check("wdx_en", 32'(pwm_en), 32'd0);
    fault = 1'b0;
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;

    // Start and stop together from IDLE
    start = 1'b1;
    stop  = 1'b1;
    cyc(2);
    check("both_en", 32'(pwm_en), 32'd0);
    check("both_busy", 32'(busy), 32'd0);
    start = 1'b0;
    stop  = 1'b0;

    // Asynchronous reset mid-ramp
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    exp_high = 4;
    ramp(3, 40, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_en", 32'(pwm_en), 32'd0);
    check("arst_high", 32'(high_cnt), 32'd4);
    check("arst_low", 32'(low_cnt), 32'd96);
    check("arst_busy", 32'(busy), 32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
